// File: rtl/if_id_buffer.sv
// Two-entry fetch/decode skid buffer: holds fetched {instr, pc_inc2} pairs in order,
// absorbs decode stalls, discards everything on flush, and blocks fetch after a HALT.
module if_id_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_inc2_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [15:0] instr_out,
  output logic [15:0] pc_inc2_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        halt_seen,
  output logic [1:0]  occupancy
);

  localparam logic [15:0] NOP = 16'h0800;

  logic [15:0] instr_q [2];
  logic [15:0] pc_q    [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        halt_q;
  logic        push;
  logic        pop;
  logic        is_halt;

  // in_ready depends only on registered state, so fetch never sees a path from out_ready.
  assign in_ready  = (count != 2'd2) && !halt_q;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign is_halt   = (instr_in[15:11] == 5'b00000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      halt_q     <= 1'b0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      halt_q <= 1'b0;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= instr_in;
        pc_q[wr_ptr]    <= pc_inc2_in;
        wr_ptr          <= ~wr_ptr;
        if (is_halt) halt_q <= 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    instr_out   = NOP;
    pc_inc2_out = 16'h0000;
    if (out_valid) begin
      instr_out   = instr_q[rd_ptr];
      pc_inc2_out = pc_q[rd_ptr];
    end
  end

  assign halt_seen = halt_q;
  assign occupancy = count;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer; each observed vector is
// {out_valid, instr_out, pc_inc2_out, occupancy, in_ready, halt_seen}.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in;
  logic [15:0] pc_inc2_in;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] instr_out;
  logic [15:0] pc_inc2_out;
  logic        out_valid;
  logic        out_ready;
  logic        halt_seen;
  logic [1:0]  occupancy;

  int tests = 0;
  int fails = 0;
  logic [36:0] obs;

  if_id_buffer dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_inc2_in(pc_inc2_in),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .instr_out(instr_out), .pc_inc2_out(pc_inc2_out), .out_valid(out_valid),
    .out_ready(out_ready), .halt_seen(halt_seen), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  assign obs = {out_valid, instr_out, pc_inc2_out, occupancy, in_ready, halt_seen};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    instr_in = 16'h0; pc_inc2_in = 16'h0;
    #1;
    tests++;
    if (obs !== {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL reset obs=%h exp=%h", obs, {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0});
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid = 1'b1; instr_in = 16'h1111; pc_inc2_in = 16'h0002;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL stream_no_bypass out_valid=%b exp=0", out_valid);
    end
    tick();
    tests++;
    if (obs !== {1'b1, 16'h1111, 16'h0002, 2'd1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL stream_w1 obs=%h exp=%h", obs, {1'b1, 16'h1111, 16'h0002, 2'd1, 1'b1, 1'b0});
    end
    instr_in = 16'h2222; pc_inc2_in = 16'h0004;
    tick();
    tests++;
    if (obs !== {1'b1, 16'h2222, 16'h0004, 2'd1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL stream_w2 obs=%h exp=%h", obs, {1'b1, 16'h2222, 16'h0004, 2'd1, 1'b1, 1'b0});
    end
    instr_in = 16'h3333; pc_inc2_in = 16'h0006;
    tick();
    tests++;
    if (obs !== {1'b1, 16'h3333, 16'h0006, 2'd1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL stream_w3 obs=%h exp=%h", obs, {1'b1, 16'h3333, 16'h0006, 2'd1, 1'b1, 1'b0});
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (obs !== {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL stream_drain obs=%h exp=%h", obs, {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; instr_in = 16'hA001; pc_inc2_in = 16'h0010;
    tick();
    instr_in = 16'hA002; pc_inc2_in = 16'h0012;
    tick();
    tests++;
    if (obs !== {1'b1, 16'hA001, 16'h0010, 2'd2, 1'b0, 1'b0}) begin
      fails++; $display("FAIL stall_full obs=%h exp=%h", obs, {1'b1, 16'hA001, 16'h0010, 2'd2, 1'b0, 1'b0});
    end
    instr_in = 16'hA003; pc_inc2_in = 16'h0014;
    tick();
    tests++;
    if (obs !== {1'b1, 16'hA001, 16'h0010, 2'd2, 1'b0, 1'b0}) begin
      fails++; $display("FAIL stall_reject obs=%h exp=%h", obs, {1'b1, 16'hA001, 16'h0010, 2'd2, 1'b0, 1'b0});
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (obs !== {1'b1, 16'hA002, 16'h0012, 2'd1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL stall_pop1 obs=%h exp=%h", obs, {1'b1, 16'hA002, 16'h0012, 2'd1, 1'b1, 1'b0});
    end
    tick();
    tests++;
    if (obs !== {1'b1, 16'hA003, 16'h0014, 2'd1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL stall_reoffer obs=%h exp=%h", obs, {1'b1, 16'hA003, 16'h0014, 2'd1, 1'b1, 1'b0});
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (obs !== {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL stall_drain obs=%h exp=%h", obs, {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; instr_in = 16'hC001; pc_inc2_in = 16'h0020;
    tick();
    instr_in = 16'hC002; pc_inc2_in = 16'h0022;
    tick();
    flush = 1'b1; out_ready = 1'b1; instr_in = 16'hBEEF; pc_inc2_in = 16'h0024;
    tick();
    tests++;
    if (obs !== {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL flush_clear obs=%h exp=%h", obs, {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0});
    end
    flush = 1'b0; in_valid = 1'b0;
    tick();
    tests++;
    if (obs !== {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL flush_no_beef obs=%h exp=%h", obs, {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0});
    end
    in_valid = 1'b1; instr_in = 16'hC003; pc_inc2_in = 16'h0040;
    tick();
    tests++;
    if (obs !== {1'b1, 16'hC003, 16'h0040, 2'd1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL flush_next_push obs=%h exp=%h", obs, {1'b1, 16'hC003, 16'h0040, 2'd1, 1'b1, 1'b0});
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_halt();
    out_ready = 1'b1;
    in_valid = 1'b1; instr_in = 16'h0000; pc_inc2_in = 16'h0050;
    tick();
    tests++;
    if (obs !== {1'b1, 16'h0000, 16'h0050, 2'd1, 1'b0, 1'b1}) begin
      fails++; $display("FAIL halt_set obs=%h exp=%h", obs, {1'b1, 16'h0000, 16'h0050, 2'd1, 1'b0, 1'b1});
    end
    instr_in = 16'h4444; pc_inc2_in = 16'h0052;
    tick();
    tests++;
    if (obs !== {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL halt_block obs=%h exp=%h", obs, {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b0, 1'b1});
    end
    tick();
    tests++;
    if (obs !== {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL halt_hold obs=%h exp=%h", obs, {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b0, 1'b1});
    end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tests++;
    if (obs !== {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL halt_flush obs=%h exp=%h", obs, {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; instr_in = 16'hD001; pc_inc2_in = 16'h0060;
    tick();
    instr_in = 16'hD002; pc_inc2_in = 16'h0062;
    tick();
    in_valid = 1'b0;
    tests++;
    if (occupancy !== 2'd2) begin
      fails++; $display("FAIL areset_pre occupancy=%0d exp=2", occupancy);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (obs !== {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL areset_now obs=%h exp=%h", obs, {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0});
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; instr_in = 16'hE001; pc_inc2_in = 16'h0070;
    tick();
    tests++;
    if (obs !== {1'b1, 16'hE001, 16'h0070, 2'd1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL areset_push obs=%h exp=%h", obs, {1'b1, 16'hE001, 16'h0070, 2'd1, 1'b1, 1'b0});
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_push_pop_wrap();
    // Pointers start at 1 here after an odd number of transfers; walk several wraps.
    out_ready = 1'b1;
    in_valid = 1'b1; instr_in = 16'h5001; pc_inc2_in = 16'h0080;
    tick();
    for (int i = 2; i <= 5; i++) begin
      instr_in = 16'h5000 + 16'(i); pc_inc2_in = 16'h0080 + 16'(2 * (i - 1));
      tick();
      tests++;
      if (obs !== {1'b1, 16'h5000 + 16'(i), 16'h0080 + 16'(2 * (i - 1)), 2'd1, 1'b1, 1'b0}) begin
        fails++; $display("FAIL pushpop_%0d obs=%h exp=%h", i, obs,
                          {1'b1, 16'h5000 + 16'(i), 16'h0080 + 16'(2 * (i - 1)), 2'd1, 1'b1, 1'b0});
      end
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (obs !== {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL pushpop_drain obs=%h exp=%h", obs, {1'b0, 16'h0800, 16'h0000, 2'd0, 1'b1, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_halt();
    test_async_reset();
    test_push_pop_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Two-entry fetch/decode skid buffer between the instruction fetch stage and the decode stage. It captures each fetched instruction with its PC+2, presents them to decode in order, absorbs decode back-pressure (RAW stalls) without losing fetched words, and discards in-flight instructions on a taken branch or jump. It also detects a fetched HALT and blocks further fetches until a flush or reset.

## Interface
- Parameters: none. Width is fixed at 16 bits. Depth is fixed at 2.
- clk  in  1  System clock; all state updates on the rising edge.
- rst  in  1  Asynchronous, active-low reset.
- instr_in  in  16  Instruction word from fetch.
- pc_inc2_in  in  16  PC+2 of instr_in.
- in_valid  in  1  instr_in/pc_inc2_in valid this cycle.
- in_ready  out  1  Buffer accepts a word this cycle. Fetch holds its PC when low.
- flush  in  1  Taken branch/jump resolved. Discard all held and incoming words.
- instr_out  out  16  Head instruction to decode. NOP (16'h0800) when empty.
- pc_inc2_out  out  16  Head PC+2. 16'h0000 when empty.
- out_valid  out  1  Head entry valid.
- out_ready  in  1  Decode consumes the head this cycle. Low during a RAW stall.
- halt_seen  out  1  A HALT has been accepted since the last flush/reset.
- occupancy  out  2  Number of valid entries, 0..2.

## Operation
- Storage: 2 entries of {instr, pc_inc2}. 1-bit write pointer wr_ptr, 1-bit read pointer rd_ptr, 2-bit count.
- in_ready = (count != 2) & !halt_seen. This is purely registered state; there is no combinational path from out_ready.
- push = in_valid & in_ready & !flush. Writes entry[wr_ptr] and toggles wr_ptr.
- pop = out_valid & out_ready & !flush. Toggles rd_ptr.
- count update: +1 on push only, −1 on pop only, unchanged on push+pop (allowed at count 1 only, since in_ready is low at 2).
- out_valid = (count != 0). instr_out/pc_inc2_out = entry[rd_ptr] when valid, else NOP/0.
- HALT detect: push with instr_in[15:11] == 5'b00000 sets halt_seen. The HALT itself is stored and delivered normally. halt_seen stays high until flush or reset.
- flush has priority over everything in its cycle:
  - count := 0, wr_ptr := rd_ptr := 0, halt_seen := 0.
  - No push and no pop.
  - Entry contents are don't-care afterwards.
- Pointers wrap modulo 2. Overflow and underflow are impossible by construction. A push when count==2 or halt_seen is ignored, because in_ready is low.

## Timing
- Reset (rst low, asynchronous): count=0, pointers=0, halt_seen=0, entries=0. Outputs: in_ready=1, out_valid=0, instr_out=16'h0800, pc_inc2_out=0, occupancy=0, halt_seen=0. Reset asserted mid-operation drops all entries immediately.
- Latency: a word pushed at edge N appears on instr_out after edge N (one cycle) if the buffer was empty. There is no same-cycle bypass.
- Throughput: 1 word/cycle sustained with out_ready held high.
- Back-pressure: with out_ready low, the buffer absorbs 2 words. in_ready falls the cycle after count reaches 2. Fetch's already-issued word is held by fetch.
- in_ready rises the cycle after the pop that makes count < 2.
- halt_seen and the resulting in_ready low become visible the cycle after the HALT push.
- flush in cycle N: out_valid=0 and in_ready=1 from edge N onward. The first post-flush word can be pushed in cycle N+1.

## Test plan
- Stream: push 0x1111/0x0002, 0x2222/0x0004, 0x3333/0x0006 on consecutive cycles with out_ready=1 -> same words out, each 1 cycle later, in order; occupancy never exceeds 1.
- Stall: out_ready=0, push 0xA001, 0xA002 -> occupancy=2, in_ready=0; 0xA003 offered is not accepted; raise out_ready -> A001, A002, then A003 (after re-offer) in order, none lost or duplicated.
- Flush: occupancy=2 with flush=1 and in_valid=1 with 0xBEEF in the same cycle -> next cycle out_valid=0, instr_out=0x0800, occupancy=0; 0xBEEF is never output.
- Halt: push 0x0000 then offer 0x4444 -> 0x0000 delivered, halt_seen=1, in_ready=0, 0x4444 not accepted; flush -> halt_seen=0, in_ready=1.
- Async reset: hold 2 entries, pull rst low between clock edges -> outputs immediately at reset values; after release, the first push appears one cycle later.
- Simultaneous push+pop at occupancy 1 -> occupancy stays 1, order preserved across the pointer wrap.
